mine_placer: RTL and testbench
==============================

# mine_placer

Generates the board's mine layout before play begins. A maximal-length LFSR drives rejection sampling, which places exactly MINES mines on distinct cells and always leaves one chosen safe cell clear. The block sits directly upstream of the per-cell block array: bit i of mine_map drives init_mine of cell i. Cells are indexed row-major, i = row*COLS + col. The game controller holds playing low until done is high.

## Interface
- ROWS, default 8: board rows.
- COLS, default 8: board columns.
- MINES, default 10: mines to place. Legal range is 0 to ROWS*COLS-1; out-of-range values fail elaboration.
- Derived constants: CELLS = ROWS*COLS; IDX_W = clog2(CELLS), minimum 1. IDX_W must be 16 or less.
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-low.
- start, input, 1: request a new layout. Sampled only in IDLE or DONE.
- seed, input, 16: LFSR seed, sampled on accepted start.
- safe_cell, input, IDX_W: cell that must never hold a mine (normally the first-clicked cell). Sampled on accepted start.
- mine_map, output, CELLS: 1 means mine.
- busy, output, 1: placement in progress.
- done, output, 1: layout complete. Held until the next accepted start or reset.
- placed, output, IDX_W+1: mines placed so far.

## Operation
- FSM states:
  - IDLE: the state after reset.
  - DRAW: placement in progress.
  - DONE: layout complete.
- Accepted start in IDLE or DONE:
  - LFSR loads seed. A seed of 0 is replaced by 16'hACE1.
  - safe_cell is latched.
  - mine_map and placed clear, and done clears.
  - Next state is DRAW, or DONE directly when MINES==0.
- Start while in DRAW is ignored. seed and safe_cell are not re-sampled.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Each step shifts left, with feedback = b15^b13^b12^b10 entering b0.
  - The LFSR steps every DRAW cycle.
- Candidate each DRAW cycle is cand = lfsr[IDX_W-1:0], taken from the pre-step value.
- Candidate is accepted only if all three hold:
  - cand < CELLS;
  - cand != latched safe_cell;
  - mine_map[cand] == 0.
- On accept, mine_map[cand] is set and placed increments.
- After the MINES-th accept, the FSM moves to DONE.
- Every cell index recurs within 65535 LFSR steps, so completion is guaranteed. Worst case is MINES*65535 cycles.
- Output bits are computed purely from the seed and parameters. The same seed and safe_cell always produce an identical mine_map.
- mine_map is stable in DONE.

## Timing
- Reset values:
  - state = IDLE;
  - mine_map = 0, placed = 0;
  - busy = 0, done = 0;
  - LFSR = 16'hACE1.
- Cycle T, start=1 in IDLE or DONE: at edge T+1, LFSR = seed (or substitute), map = 0, busy = 1, done = 0.
- Cycle T+1 is the first DRAW evaluation. Each DRAW cycle evaluates at most one candidate.
- The MINES-th accept at cycle N takes effect at edge N+1: the final map bit is set, placed = MINES, busy = 0, done = 1, all in the same cycle.
- MINES==0: done = 1 and busy = 0 at T+1, with the map all zero.
- Reset low at any cycle, including mid-DRAW: reset values apply at the next edge. The partial map is discarded.
- busy and done are never both high.
- done-then-start: done drops at T+1, in the same edge that clears the map.

## Structure
- Shared package minesweeper_pkg holds:
  - ROWS, COLS, CELLS, IDX_W;
  - LFSR tap constant and default seed 16'hACE1;
  - the FSM state enum (IDLE, DRAW, DONE).
- Sub-module lfsr16, used by mine_placer:
  - ports: clk, load, load_val, step, q;
  - load has priority over step.
- All else is inline in mine_placer: FSM, acceptance compare, map register, counter.

## Test plan
- Reset: after reset low for 2 cycles, check mine_map = 0, busy = 0, done = 0, placed = 0. Check no activity without start.
- 8x8, MINES=10, seed 16'h1234, safe_cell 0: done within 2000 cycles; popcount(mine_map) = 10; bit 0 = 0; map matches the golden model's exact bit pattern and accept cycles.
- Seed 0 versus seed 16'hACE1 with the same safe_cell: identical mine_map and identical cycle of done.
- Start pulsed mid-DRAW with a different seed: ignored; final map equals the uninterrupted run. A second start in DONE with the same inputs reproduces the map bit-exactly.
- Reset asserted mid-DRAW after 3 accepts: next cycle map = 0, placed = 0, state IDLE. A fresh start then yields the normal result.
- 9x9, MINES=80, safe_cell 40: candidates 81-127 are never accepted; final map = all ones except bit 40. Separately, MINES=0 gives done at T+1 with an empty map.

Source files
------------

// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper board logic.
//   - default board geometry (ROWS, COLS, CELLS, IDX_W)
//   - LFSR tap mask and default seed
//   - mine placer FSM state encoding
package minesweeper_pkg;

    // Index width for a board of the given size, never below one bit.
    function automatic int idx_width(input int cells);
        return (cells > 2) ? $clog2(cells) : 1;
    endfunction

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = idx_width(CELLS);

    // x^16+x^14+x^13+x^11+1 -> feedback from bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with the feedback bit entering b0.
// Ports:
//   clk      - clock
//   load     - load load_val (has priority over step)
//   load_val - value to load
//   step     - advance one step
//   q        - current register value
module lfsr16
    import minesweeper_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/mine_placer.sv
// Places exactly MINES mines on distinct cells by rejection sampling an LFSR,
// never on the latched safe cell. Bit i of mine_map is cell i (row-major).
// Ports:
//   clk       - clock
//   reset     - synchronous, active-low reset
//   start     - request a new layout (honoured in IDLE or DONE only)
//   seed      - LFSR seed, sampled on accepted start (0 -> default seed)
//   safe_cell - cell kept mine-free, sampled on accepted start
//   mine_map  - one bit per cell, 1 = mine
//   busy      - placement in progress
//   done      - layout complete, held until next accepted start or reset
//   placed    - mines placed so far
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | after reset, waiting for start
// DRAW  | one candidate evaluated per cycle
// DONE  | layout complete, map frozen
module mine_placer #(
    parameter  int ROWS  = minesweeper_pkg::ROWS,
    parameter  int COLS  = minesweeper_pkg::COLS,
    parameter  int MINES = 10,
    localparam int CELLS = ROWS * COLS,
    localparam int IDX_W = minesweeper_pkg::idx_width(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [IDX_W-1:0] safe_cell,
    output logic [CELLS-1:0] mine_map,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   placed
);

    generate
        if (MINES < 0 || MINES > CELLS - 1) begin : g_bad_mines
            $error("mine_placer: MINES out of range");
        end
        if (IDX_W > 16) begin : g_bad_idx
            $error("mine_placer: board too large for 16-bit LFSR");
        end
    endgenerate

    localparam logic [IDX_W:0] CELLS_W = CELLS[IDX_W:0];
    localparam int             LAST_I  = (MINES > 0) ? MINES - 1 : 0;
    localparam logic [IDX_W:0] LAST_W  = LAST_I[IDX_W:0];

    minesweeper_pkg::state_t state;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_load_val;
    logic             lfsr_load;
    logic [IDX_W-1:0] safe_q;
    logic [IDX_W-1:0] cand;
    logic             start_ok;
    logic             accept;

    assign start_ok = start && (state != minesweeper_pkg::DRAW);
    assign cand     = lfsr_q[IDX_W-1:0];

    // Reset reuses the load path so the LFSR needs no reset port of its own.
    always_comb begin
        lfsr_load     = !reset || start_ok;
        lfsr_load_val = minesweeper_pkg::LFSR_DEFAULT_SEED;
        if (reset && seed != 16'h0000) begin
            lfsr_load_val = seed;
        end
    end

    lfsr16 u_lfsr (
        .clk      (clk),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .step     (state == minesweeper_pkg::DRAW),
        .q        (lfsr_q)
    );

    // Range check first so the map is only indexed with a valid cell.
    always_comb begin
        accept = 1'b0;
        if (({1'b0, cand} < CELLS_W) && (cand != safe_q)) begin
            accept = !mine_map[cand];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= minesweeper_pkg::IDLE;
            mine_map <= '0;
            placed   <= '0;
            safe_q   <= '0;
        end else if (start_ok) begin
            safe_q   <= safe_cell;
            mine_map <= '0;
            placed   <= '0;
            state    <= (MINES == 0) ? minesweeper_pkg::DONE : minesweeper_pkg::DRAW;
        end else if (state == minesweeper_pkg::DRAW && accept) begin
            mine_map[cand] <= 1'b1;
            placed         <= placed + 1'b1;
            if (placed == LAST_W) begin
                state <= minesweeper_pkg::DONE;
            end
        end
    end

    assign busy = (state == minesweeper_pkg::DRAW);
    assign done = (state == minesweeper_pkg::DONE);

endmodule

// File: tb/tb_mine_placer.sv
module tb_mine_placer;

    typedef struct {
        int k;
        int cand;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] seed;
    logic [7:0]  safe;
    int          sel;

    logic [63:0] map_a, map_c;
    logic [80:0] map_b;
    logic [6:0]  placed_a, placed_c;
    logic [7:0]  placed_b;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

    logic [127:0] obs_map;
    int           obs_placed;
    logic         obs_busy, obs_done;

    int errors = 0;
    int checks = 0;

    acc_t         exp_q[$];
    logic [127:0] exp_map;

    always #5 clk = ~clk;

    mine_placer #(.ROWS(8), .COLS(8), .MINES(10)) dut_a (
        .clk(clk), .reset(reset), .start(start && sel == 0), .seed(seed),
        .safe_cell(safe[5:0]), .mine_map(map_a), .busy(busy_a), .done(done_a),
        .placed(placed_a));

    mine_placer #(.ROWS(9), .COLS(9), .MINES(80)) dut_b (
        .clk(clk), .reset(reset), .start(start && sel == 1), .seed(seed),
        .safe_cell(safe[6:0]), .mine_map(map_b), .busy(busy_b), .done(done_b),
        .placed(placed_b));

    mine_placer #(.ROWS(8), .COLS(8), .MINES(0)) dut_c (
        .clk(clk), .reset(reset), .start(start && sel == 2), .seed(seed),
        .safe_cell(safe[5:0]), .mine_map(map_c), .busy(busy_c), .done(done_c),
        .placed(placed_c));

    always_comb begin
        obs_map    = '0;
        obs_placed = 0;
        obs_busy   = 1'b0;
        obs_done   = 1'b0;
        case (sel)
            0: begin obs_map = {64'b0, map_a}; obs_placed = int'(placed_a); obs_busy = busy_a; obs_done = done_a; end
            1: begin obs_map = {47'b0, map_b}; obs_placed = int'(placed_b); obs_busy = busy_b; obs_done = done_b; end
            default: begin obs_map = {64'b0, map_c}; obs_placed = int'(placed_c); obs_busy = busy_c; obs_done = done_c; end
        endcase
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Golden placement: accepted candidates with their DRAW-cycle index k.
    task automatic build_expect(input int mines, input int cells, input int idxw,
                                input logic [15:0] sd, input int sf);
        logic [15:0] l;
        int cnt;
        int c;
        exp_q.delete();
        exp_map = '0;
        l = (sd == 16'h0) ? 16'hACE1 : sd;
        cnt = 0;
        for (int k = 0; k < 300000 && cnt < mines; k++) begin
            c = int'(l) & ((1 << idxw) - 1);
            if (c < cells && c != sf && !exp_map[c]) begin
                exp_q.push_back('{k: k, cand: c});
                exp_map[c] = 1'b1;
                cnt++;
            end
            l = lfsr_next(l);
        end
    endtask

    // Starts a layout on DUT s and checks every accept against the scoreboard.
    // A start with a different seed/safe cell is pulsed at edge intr (0 = none).
    task automatic run_and_check(input int s, input logic [15:0] sd, input int sf,
                                 input int intr, input int budget,
                                 output int done_edge, output logic [127:0] final_map);
        int mines, cells, idxw, e, prev_placed;
        logic [127:0] prev_map;
        acc_t a;
        mines = (s == 0) ? 10 : (s == 1) ? 80 : 0;
        cells = (s == 1) ? 81 : 64;
        idxw  = (s == 1) ? 7 : 6;
        build_expect(mines, cells, idxw, sd, sf);
        @(negedge clk);
        sel   = s;
        seed  = sd;
        safe  = sf[7:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 1;
        check("start_map_clear", obs_map, '0);
        check("start_placed_clear", obs_placed, 0);
        check("start_busy", obs_busy, (mines != 0));
        check("start_done", obs_done, (mines == 0));
        prev_placed = 0;
        prev_map    = '0;
        while (!obs_done && e < budget) begin
            @(posedge clk);
            e++;
            #1;
            if (intr != 0 && e == intr) begin
                start = 1'b1;
                seed  = 16'h5555;
                safe  = 8'd7;
            end else if (intr != 0 && e == intr + 1) begin
                start = 1'b0;
            end
            if (obs_busy && obs_done) check("busy_done_exclusive", 1, 0);
            if (obs_placed != prev_placed) begin
                check("placed_step", obs_placed, prev_placed + 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_accept", obs_placed, mines);
                end else begin
                    a = exp_q.pop_front();
                    check("accept_cycle", e, a.k + 2);
                    check("accept_cell", obs_map ^ prev_map, 128'b1 << a.cand);
                end
                prev_placed = obs_placed;
                prev_map    = obs_map;
            end
        end
        start = 1'b0;
        check("done_reached", obs_done, 1);
        check("queue_drained", exp_q.size(), 0);
        check("final_map", obs_map, exp_map);
        check("final_placed", obs_placed, mines);
        check("final_busy", obs_busy, 0);
        done_edge = e;
        final_map = obs_map;
        repeat (3) @(posedge clk);
        #1;
        check("done_held", obs_done, 1);
        check("map_stable", obs_map, final_map);
    endtask

    initial begin
        int           de_a, de_b, de_x, wait_n;
        logic [127:0] map_ref, map_x, full81;

        reset = 1'b0;
        start = 1'b0;
        seed  = 16'h0;
        safe  = 8'h0;
        sel   = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_map", obs_map, '0);
        check("reset_busy", obs_busy, 0);
        check("reset_done", obs_done, 0);
        check("reset_placed", obs_placed, 0);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_map", obs_map, '0);
        check("idle_busy", obs_busy, 0);
        check("idle_done", obs_done, 0);
        check("idle_placed", obs_placed, 0);

        // 8x8, 10 mines, seed 1234, safe 0.
        run_and_check(0, 16'h1234, 0, 0, 2000, de_a, map_ref);
        check("popcount10", $countones(map_ref), 10);
        check("safe_bit0", map_ref[0], 0);

        // Seed 0 substitutes the default seed.
        run_and_check(0, 16'h0000, 5, 0, 2000, de_a, map_x);
        run_and_check(0, 16'hACE1, 5, 0, 2000, de_b, map_ref);
        check("seed0_map", map_x, map_ref);
        check("seed0_done_cycle", de_a, de_b);

        // Start mid-DRAW is ignored; a repeated start reproduces the layout.
        run_and_check(0, 16'h1234, 0, 3, 2000, de_a, map_ref);
        run_and_check(0, 16'h1234, 0, 0, 2000, de_b, map_x);
        check("repeat_map", map_x, map_ref);
        check("repeat_done_cycle", de_b, de_a);

        // Reset mid-DRAW after three accepts.
        @(negedge clk);
        sel   = 0;
        seed  = 16'h1234;
        safe  = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_n = 0;
        while (obs_placed < 3 && wait_n < 2000) begin
            @(negedge clk);
            wait_n++;
        end
        check("reached_three", obs_placed, 3);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_map", obs_map, '0);
        check("midreset_placed", obs_placed, 0);
        check("midreset_busy", obs_busy, 0);
        check("midreset_done", obs_done, 0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midreset_idle", obs_busy, 0);
        run_and_check(0, 16'h1234, 0, 0, 2000, de_a, map_x);

        // 9x9, 80 mines, safe cell 40: every cell but 40 is mined.
        run_and_check(1, 16'h1234, 40, 0, 70000, de_a, map_x);
        full81 = (128'b1 << 81) - 128'b1;
        full81[40] = 1'b0;
        check("full_board", map_x, full81);

        // No mines: done right after the start edge with an empty map.
        run_and_check(2, 16'hBEEF, 3, 0, 10, de_a, map_x);
        check("zero_mines_edge", de_a, 1);
        check("zero_mines_map", map_x, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
